// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: state codes,
// opcodes, datapath select codes and the control-word struct.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_ADDI_WB   = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pcen;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctl_t;

  // Last state of each instruction; leaving one of these retires it.
  function automatic logic is_final(input state_t s);
    return (s == S_MEM_WB) || (s == S_MEM_WRITE) || (s == S_R_WB) ||
           (s == S_ADDI_WB) || (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_perf.sv
// Cycle and retired-instruction counters for the multi-cycle controller.
// Only instantiated when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        instr_done,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  // Both counters wrap naturally; freeze holds them while the core is halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (!freeze) begin
      cycle_q <= cycle_q + 32'd1;
      if (instr_done) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM driving a shared ALU/unified-memory datapath.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCEn,
  output logic [1:0]  PCSource,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  State,
  output logic        IllegalOp
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
`endif
);

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;
  logic       illegal_q;
  ctl_t       ctl;
  ctl_t       ctl_o;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= Opcode;
      if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  // Memory handshake: a request (MemRead or MemWrite) is held constant from
  // the first cycle of FETCH/MEM_READ/MEM_WRITE until the cycle MemReady=1,
  // which completes the access; MemReady is don't-care in every other state.
  always_comb begin
    next_state = state;
    ctl        = '0;
    case (state)
      S_FETCH: begin
        ctl.memread = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
        ctl.aluop   = ALUOP_ADD;
        if (MemReady) begin
          ctl.irwrite  = 1'b1;
          ctl.pcen     = 1'b1;
          ctl.pcsource = PCSRC_ALU;
          next_state   = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alusrcb = SRCB_IMM_SH;
        ctl.aluop   = ALUOP_ADD;
        case (Opcode)
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_RTYPE:       next_state = S_EXEC;
          OP_ADDI:        next_state = S_ADDI_EXEC;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:           next_state = S_JUMP;
          default:        next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_ADD;
        next_state  = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
        if (MemReady) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXEC: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_B;
        ctl.aluop   = ALUOP_FUNCT;
        next_state  = S_R_WB;
      end
      S_R_WB: begin
        ctl.regwrite = 1'b1;
        ctl.regdst   = 1'b1;
        next_state   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_ADD;
        next_state  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctl.regwrite = 1'b1;
        next_state   = S_FETCH;
      end
      S_BRANCH: begin
        // Branch sense comes from the opcode captured in DECODE, not the live IR.
        ctl.alusrca  = 1'b1;
        ctl.alusrcb  = SRCB_B;
        ctl.aluop    = ALUOP_SUB;
        ctl.pcsource = PCSRC_ALUOUT;
        ctl.pcen     = (op_q == OP_BNE) ? ~Zero : Zero;
        next_state   = S_FETCH;
      end
      S_JUMP: begin
        ctl.pcen     = 1'b1;
        ctl.pcsource = PCSRC_JUMP;
        next_state   = S_FETCH;
      end
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_FETCH;
    endcase
  end

  // Reset masks every output so an abandoned access never commits.
  assign ctl_o     = Rst ? '0 : ctl;
  assign PCEn      = ctl_o.pcen;
  assign PCSource  = ctl_o.pcsource;
  assign IorD      = ctl_o.iord;
  assign MemRead   = ctl_o.memread;
  assign MemWrite  = ctl_o.memwrite;
  assign IRWrite   = ctl_o.irwrite;
  assign MemtoReg  = ctl_o.memtoreg;
  assign RegDst    = ctl_o.regdst;
  assign RegWrite  = ctl_o.regwrite;
  assign ALUSrcA   = ctl_o.alusrca;
  assign ALUSrcB   = ctl_o.alusrcb;
  assign ALUOp     = ctl_o.aluop;
  assign State     = Rst ? 4'd0 : state;
  assign IllegalOp = ~Rst & illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic instr_done;
  assign instr_done = is_final(state) && (next_state == S_FETCH);

  multicycle_ctrl_perf u_perf (
    .clk         (Clk),
    .rst         (Rst),
    .freeze      (state == S_ILLEGAL),
    .instr_done  (instr_done),
    .cycle_count (CycleCount),
    .instr_count (InstrCount)
  );
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// words are queued per scenario and compared as the FSM steps.
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [5:0]  Opcode = 6'h00;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [3:0]  State;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] CycleCount, InstrCount;
  logic [31:0] exp_cyc = '0;
  logic [31:0] exp_ins = '0;
`endif

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  multicycle_controller dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .State(State), .IllegalOp(IllegalOp)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
  );

  always #5 Clk = ~Clk;

  // {State, IllegalOp, PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite,
  //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp}
  logic [19:0] obs;
  assign obs = {State, IllegalOp, PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp};

  localparam logic [19:0] C_RST     = 20'h0;
  localparam logic [19:0] C_FETCH_W = {4'd0,  1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
  localparam logic [19:0] C_FETCH_G = {4'd0,  1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
  localparam logic [19:0] C_DECODE  = {4'd1,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00};
  localparam logic [19:0] C_MADDR   = {4'd2,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
  localparam logic [19:0] C_MREAD   = {4'd3,  1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] C_MWB     = {4'd4,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] C_MWRITE  = {4'd5,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] C_EXEC    = {4'd6,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10};
  localparam logic [19:0] C_RWB     = {4'd7,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] C_AEXEC   = {4'd8,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
  localparam logic [19:0] C_AWB     = {4'd9,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] C_BR_T    = {4'd10, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
  localparam logic [19:0] C_BR_N    = {4'd10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
  localparam logic [19:0] C_JUMP    = {4'd11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] C_ILL     = {4'd12, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

  // One clock: drive inputs at the falling edge, compare just after, commit on the rising edge.
  task automatic run_cycle(input string tag, input logic rst_v, input logic [5:0] op,
                           input logic mr, input logic z);
    logic [19:0] exp;
    @(negedge Clk);
    Rst = rst_v; Opcode = op; MemReady = mr; Zero = z;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: queue empty, got %h", tag, obs);
      exp = C_RST;
    end else begin
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h (state %0d vs %0d)", tag, obs, exp, obs[19:16], exp[19:16]);
      end
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    if (!rst_v) begin
      checks++;
      if (CycleCount !== exp_cyc) begin
        failures++;
        $display("FAIL %s_cycles: got %0d expected %0d", tag, CycleCount, exp_cyc);
      end
      checks++;
      if (InstrCount !== exp_ins) begin
        failures++;
        $display("FAIL %s_instrs: got %0d expected %0d", tag, InstrCount, exp_ins);
      end
    end
    if (rst_v) begin
      exp_cyc = '0;
      exp_ins = '0;
    end else if (exp[19:16] != 4'd12) begin
      exp_cyc = exp_cyc + 32'd1;
    end
`endif
  endtask

  task automatic retire();
`ifdef MULTICYCLE_CTRL_PERF_EN
    exp_ins = exp_ins + 32'd1;
`endif
  endtask

  // Expected sequence of a supported instruction with MemReady tied high.
  task automatic push_instr(input logic [5:0] op, input logic z, output int len);
    exp_q.push_back(C_FETCH_G);
    exp_q.push_back(C_DECODE);
    case (op)
      6'h00: begin exp_q.push_back(C_EXEC); exp_q.push_back(C_RWB); len = 4; end
      6'h23: begin exp_q.push_back(C_MADDR); exp_q.push_back(C_MREAD); exp_q.push_back(C_MWB); len = 5; end
      6'h2B: begin exp_q.push_back(C_MADDR); exp_q.push_back(C_MWRITE); len = 4; end
      6'h08: begin exp_q.push_back(C_AEXEC); exp_q.push_back(C_AWB); len = 4; end
      6'h04: begin exp_q.push_back(z ? C_BR_T : C_BR_N); len = 3; end
      6'h05: begin exp_q.push_back(z ? C_BR_N : C_BR_T); len = 3; end
      default: begin exp_q.push_back(C_JUMP); len = 3; end
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic z);
    int len;
    push_instr(op, z, len);
    for (int i = 0; i < len; i++) run_cycle(tag, 1'b0, op, 1'b1, z);
    retire();
  endtask

  task automatic test_reset();
    repeat (3) exp_q.push_back(C_RST);
    repeat (3) run_cycle("reset", 1'b1, 6'h3F, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_rtype();
    run_instr("rtype", 6'h00, 1'b0);
    run_instr("addi", 6'h08, 1'b1);
    run_instr("sw", 6'h2B, 1'b0);
    run_instr("jump", 6'h02, 1'b0);
  endtask

  task automatic test_lw_stall();
    logic mr_seq[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(C_FETCH_G);
    exp_q.push_back(C_DECODE);
    exp_q.push_back(C_MADDR);
    repeat (4) exp_q.push_back(C_MREAD);
    exp_q.push_back(C_MWB);
    for (int i = 0; i < 8; i++) begin
      // MemReady is noise outside FETCH/MEM_READ.
      logic mr = (i == 1 || i == 2 || i == 7) ? 1'($urandom_range(0, 1)) : mr_seq[i];
      run_cycle("lw_stall", 1'b0, 6'h23, mr, 1'b0);
    end
    retire();
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 6'h04, 1'b1);
    run_instr("beq_z0", 6'h04, 1'b0);
    run_instr("bne_z1", 6'h05, 1'b1);
    run_instr("bne_z0", 6'h05, 1'b0);
  endtask

  task automatic test_fetch_stall();
    repeat (2) exp_q.push_back(C_FETCH_W);
    exp_q.push_back(C_FETCH_G);
    exp_q.push_back(C_DECODE);
    exp_q.push_back(C_JUMP);
    run_cycle("fetch_stall", 1'b0, 6'h02, 1'b0, 1'b0);
    run_cycle("fetch_stall", 1'b0, 6'h02, 1'b0, 1'b0);
    run_cycle("fetch_stall", 1'b0, 6'h02, 1'b1, 1'b0);
    run_cycle("fetch_stall", 1'b0, 6'h02, 1'b0, 1'b0);
    run_cycle("fetch_stall", 1'b0, 6'h02, 1'b0, 1'b0);
    retire();
  endtask

  task automatic test_opcode_latch();
    // beq decoded, IR shows bne during BRANCH: still taken on Zero=1.
    exp_q.push_back(C_FETCH_G); exp_q.push_back(C_DECODE); exp_q.push_back(C_BR_T);
    run_cycle("latch_beq", 1'b0, 6'h04, 1'b1, 1'b1);
    run_cycle("latch_beq", 1'b0, 6'h04, 1'b1, 1'b1);
    run_cycle("latch_beq", 1'b0, 6'h05, 1'b1, 1'b1);
    retire();
    // lw decoded, IR shows sw during MEM_ADDR: still a read.
    exp_q.push_back(C_FETCH_G); exp_q.push_back(C_DECODE); exp_q.push_back(C_MADDR);
    exp_q.push_back(C_MREAD); exp_q.push_back(C_MWB);
    run_cycle("latch_lw", 1'b0, 6'h23, 1'b1, 1'b0);
    run_cycle("latch_lw", 1'b0, 6'h23, 1'b1, 1'b0);
    run_cycle("latch_lw", 1'b0, 6'h2B, 1'b1, 1'b0);
    run_cycle("latch_lw", 1'b0, 6'h2B, 1'b1, 1'b0);
    run_cycle("latch_lw", 1'b0, 6'h2B, 1'b1, 1'b0);
    retire();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
    for (int n = 0; n < 12; n++)
      run_instr("b2b", ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
  endtask

  task automatic test_rst_stall();
    exp_q.push_back(C_FETCH_G); exp_q.push_back(C_DECODE); exp_q.push_back(C_MADDR);
    exp_q.push_back(C_MWRITE); exp_q.push_back(C_RST); exp_q.push_back(C_FETCH_W);
    run_cycle("rst_stall", 1'b0, 6'h2B, 1'b1, 1'b0);
    run_cycle("rst_stall", 1'b0, 6'h2B, 1'b1, 1'b0);
    run_cycle("rst_stall", 1'b0, 6'h2B, 1'b1, 1'b0);
    run_cycle("rst_stall", 1'b0, 6'h2B, 1'b0, 1'b0);
    run_cycle("rst_stall", 1'b1, 6'h2B, 1'b0, 1'b0);
    run_cycle("rst_stall", 1'b0, 6'h2B, 1'b0, 1'b0);
    exp_q.push_back(C_FETCH_G); exp_q.push_back(C_DECODE); exp_q.push_back(C_JUMP);
    repeat (3) run_cycle("rst_stall_j", 1'b0, 6'h02, 1'b1, 1'b0);
    retire();
  endtask

  task automatic test_illegal();
    exp_q.push_back(C_FETCH_G); exp_q.push_back(C_DECODE);
    repeat (10) exp_q.push_back(C_ILL);
    exp_q.push_back(C_RST); exp_q.push_back(C_FETCH_G);
    run_cycle("illegal", 1'b0, 6'h3F, 1'b1, 1'b0);
    run_cycle("illegal", 1'b0, 6'h3F, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      run_cycle("illegal_hold", 1'b0, 6'($urandom_range(0, 63)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_cycle("illegal_rst", 1'b1, 6'h00, 1'b1, 1'b0);
    run_cycle("illegal_clr", 1'b0, 6'h00, 1'b1, 1'b0);
    exp_q.push_back(C_DECODE); exp_q.push_back(C_EXEC); exp_q.push_back(C_RWB);
    repeat (3) run_cycle("illegal_after", 1'b0, 6'h00, 1'b1, 1'b0);
    retire();
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  task automatic test_wrap();
    @(negedge Clk);
    Rst = 1'b0; MemReady = 1'b0;
    force dut.u_perf.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.cycle_q;
    #1;
    checks++;
    if (CycleCount !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preload: got %h expected ffffffff", CycleCount);
    end
    @(posedge Clk); #1;
    checks++;
    if (CycleCount !== 32'h0) begin
      failures++;
      $display("FAIL wrap: got %h expected 00000000", CycleCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_fetch_stall();
    test_opcode_latch();
    test_back_to_back();
    test_rst_stall();
    test_illegal();
`ifdef MULTICYCLE_CTRL_PERF_EN
    test_wrap();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the shared ALU / DataMemory datapath as a multi-cycle MIPS subset processor, replacing the single-cycle control decode. Each instruction takes 3–5 states, plus any memory stall cycles. A single unified memory is used for instruction fetch and data access, selected by IorD. Sits between the instruction register / opcode field and the datapath muxes, register file, ALUControl and DataMemory.

## Interface
Parameters:
- none (encodings fixed in package)

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-high reset
- Opcode  in  6  Instruction[31:26] from instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current read/write this cycle
- PCEn  out  1  PC register write enable (unconditional or taken branch)
- PCSource  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 reserved
- State  out  4  current state (debug)
- IllegalOp  out  1  sticky: unsupported opcode decoded

## Operation
- Supported opcodes:
  - R-type 0x00
  - lw 0x23
  - sw 0x2B
  - beq 0x04
  - bne 0x05
  - addi 0x08
  - j 0x02
- States and transitions:
  - FETCH: drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. Holds while MemReady=0. In the cycle MemReady=1 it asserts IRWrite=1, PCEn=1, PCSource=00, then goes to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatches on Opcode:
    - lw/sw → MEM_ADDR
    - R-type → EXEC
    - addi → ADDI_EXEC
    - beq/bne → BRANCH
    - j → JUMP
    - anything else → ILLEGAL
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEM_READ; sw → MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1; holds until MemReady, then → MEM_WB.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1; holds until MemReady, then → FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCEn = Zero for beq, !Zero for bne. The opcode is latched in DECODE, so later IR changes cannot affect this. → FETCH.
  - JUMP: PCEn=1, PCSource=10 → FETCH.
  - ILLEGAL: all enables 0; IllegalOp=1; stays until Rst.
- Control outputs not listed for a state are 0.
- MemRead and MemWrite are never asserted in the same cycle.
- Request signals stay stable throughout a stall.

## Timing
- Outputs are combinational from the state register, plus MemReady (FETCH only) and Zero (BRANCH only).
- While Rst=1: every output is 0, including State=0 (FETCH encoding) and IllegalOp=0.
- The state register enters FETCH on the first edge with Rst=1.
- With MemReady tied high, cycles per instruction are: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.
- Each cycle with MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Rst asserted during a stall abandons the access. There is no write-back and no PC update; the next state is FETCH.
- MemReady is ignored in every non-memory state.

## Configuration
- MULTICYCLE_CTRL_PERF_EN defined:
  - Adds outputs CycleCount[31:0] and InstrCount[31:0]. Both are cleared by Rst.
  - CycleCount increments every cycle outside reset.
  - InstrCount increments on each transition into FETCH from a final state (MEM_WB, MEM_WRITE, R_WB, ADDI_WB, BRANCH, JUMP).
  - Both counters wrap modulo 2^32 and freeze in ILLEGAL.
- Undefined: these ports and registers are absent.

## Structure
- Package multicycle_ctrl_pkg holds:
  - 4-bit state localparams
  - opcode constants
  - ALUOp, PCSource and ALUSrcB codes
- One sub-module, multicycle_ctrl_perf: the two counters, instantiated only under MULTICYCLE_CTRL_PERF_EN.

## Test plan
- Reset, then R-type (Opcode=0x00) with MemReady=1 → State sequence FETCH, DECODE, EXEC, R_WB, FETCH. RegWrite=1 and RegDst=1 only in R_WB. InstrCount=1.
- lw with MemReady low for 3 cycles in MEM_READ → MemRead=1 and IorD=1 held for 4 cycles, then MEM_WB with MemtoReg=1 and RegWrite=1. 8 cycles total.
- beq with Zero=1 → PCEn=1, PCSource=01 in BRANCH. bne with Zero=1 → PCEn=0. 3 cycles each.
- Opcode=0x3F → ILLEGAL, IllegalOp=1, all enables 0 for 10 cycles. Rst=1 then clears it to FETCH.
- Rst=1 during a sw stall in MEM_WRITE → MemWrite=0 that cycle; FETCH next; InstrCount unchanged.
- With PERF_EN: preload CycleCount to 0xFFFFFFFF via a long run or force → wraps to 0 on the next cycle.
